// File: rtl/uart_pkg.sv
// Shared UART definitions: frame length limits, parity helper and receiver state encoding.
package uart_pkg;

    localparam logic [3:0] LEN_MIN = 4'd5;
    localparam logic [3:0] LEN_MAX = 4'd8;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        DATA   = 3'd1,
        PARITY = 3'd2,
        STOP1  = 3'd3,
        STOP2  = 3'd4,
        DONE   = 3'd5
    } rx_state_t;

    function automatic logic len_legal(input logic [3:0] len);
        return (len >= LEN_MIN) && (len <= LEN_MAX);
    endfunction

    // ty=1 gives ^data, ty=0 gives ~^data, over the low len bits only.
    function automatic logic calc_parity(input logic [7:0] data, input logic [3:0] len,
                                         input logic ty);
        logic [7:0] masked;
        masked = '0;
        for (int i = 0; i < 8; i++) begin
            if (4'(i) < len) masked[i] = data[i];
        end
        return ty ? (^masked) : (~^masked);
    endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// Input synchroniser for the serial line; flops reset to the idle-high level.
module uart_rx_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    generate
        if (SYNC_STAGES == 0) begin : g_bypass
            assign q = d;
        end else begin : g_chain
            logic [SYNC_STAGES-1:0] stage;

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    stage <= '1;
                end else begin
                    stage[0] <= d;
                    for (int i = 1; i < SYNC_STAGES; i++) begin
                        stage[i] <= stage[i-1];
                    end
                end
            end

            assign q = stage[SYNC_STAGES-1];
        end
    endgenerate

endmodule

// File: rtl/uart_rx.sv
// UART receiver: one line sample per clock, 5..8 data bits LSB first, optional parity,
// one or two stop bits. o_rx_done strobes for one cycle with data and error flags.
module uart_rx
    import uart_pkg::*;
#(
    parameter int SYNC_STAGES = 2
) (
    input  logic       i_rx_clk,
    input  logic       rst,
    input  logic       i_rx,
    input  logic [3:0] i_len,
    input  logic       i_parity_ty,
    input  logic       i_parity_en,
    input  logic       i_stop2,
    output logic [7:0] o_rx_data,
    output logic       o_rx_done,
    output logic       o_rx_er,
    output logic       o_parity_er,
    output logic       o_frame_er,
    output logic       o_rx_busy,
    output rx_state_t  o_state
);

    // Output protocol: o_rx_done is a single-cycle strobe with no back-pressure;
    // o_rx_data and the error flags are valid in that cycle and held afterwards.

    logic       rxs;
    rx_state_t  state_q;
    rx_state_t  state_next;
    logic [3:0] len_q;
    logic       pty_q;
    logic       pen_q;
    logic       s2_q;
    logic [7:0] shift_q;
    logic [2:0] cnt_q;
    logic       perr_q;
    logic       ferr_q;
    logic [7:0] data_q;
    logic       last_bit;

    uart_rx_sync #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_sync (
        .clk(i_rx_clk),
        .rst(rst),
        .d  (i_rx),
        .q  (rxs)
    );

    assign last_bit = ({1'b0, cnt_q} == (len_q - 4'd1));

    always_ff @(posedge i_rx_clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_next;
        end
    end

    always_comb begin
        state_next = state_q;
        case (state_q)
            IDLE:    if (!rxs) state_next = DATA;
            DATA:    if (last_bit) state_next = pen_q ? PARITY : STOP1;
            PARITY:  state_next = STOP1;
            STOP1:   state_next = s2_q ? STOP2 : DONE;
            STOP2:   state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // An illegal length is flagged up front and the frame is taken as 8 bits.
    always_ff @(posedge i_rx_clk or posedge rst) begin
        if (rst) begin
            len_q   <= LEN_MAX;
            pty_q   <= 1'b0;
            pen_q   <= 1'b0;
            s2_q    <= 1'b0;
            shift_q <= '0;
            cnt_q   <= '0;
            perr_q  <= 1'b0;
            ferr_q  <= 1'b0;
            data_q  <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (!rxs) begin
                        len_q   <= len_legal(i_len) ? i_len : LEN_MAX;
                        pty_q   <= i_parity_ty;
                        pen_q   <= i_parity_en;
                        s2_q    <= i_stop2;
                        shift_q <= '0;
                        cnt_q   <= '0;
                        perr_q  <= 1'b0;
                        ferr_q  <= !len_legal(i_len);
                    end
                end
                DATA: begin
                    shift_q[cnt_q] <= rxs;
                    cnt_q          <= cnt_q + 3'd1;
                end
                PARITY: begin
                    perr_q <= (rxs != calc_parity(shift_q, len_q, pty_q));
                end
                STOP1, STOP2: begin
                    if (!rxs) ferr_q <= 1'b1;
                end
                default: begin
                end
            endcase

            if (state_next == DONE) begin
                data_q <= shift_q;
            end
        end
    end

    assign o_rx_data   = data_q;
    assign o_rx_done   = (state_q == DONE);
    assign o_parity_er = perr_q;
    assign o_frame_er  = ferr_q;
    assign o_rx_er     = perr_q | ferr_q;
    assign o_rx_busy   = (state_q != IDLE);
    assign o_state     = state_q;

endmodule

// File: tb/tb_uart_rx.sv
// Bench for uart_rx: drives the serial line directly into a direct-sampling instance
// and a two-stage synchronised instance, checking both against expected frames.
module tb_uart_rx;
    import uart_pkg::*;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic       rx;
    logic [3:0] len;
    logic       pty;
    logic       pen;
    logic       s2;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [7:0] data0, data1;
    logic       done0, done1, er0, er1, perr0, perr1, ferr0, ferr1, busy0, busy1;
    rx_state_t  state0, state1;

    uart_rx #(.SYNC_STAGES(0)) dut0 (
        .i_rx_clk(clk), .rst(rst), .i_rx(rx), .i_len(len), .i_parity_ty(pty),
        .i_parity_en(pen), .i_stop2(s2), .o_rx_data(data0), .o_rx_done(done0),
        .o_rx_er(er0), .o_parity_er(perr0), .o_frame_er(ferr0), .o_rx_busy(busy0),
        .o_state(state0)
    );

    uart_rx #(.SYNC_STAGES(2)) dut1 (
        .i_rx_clk(clk), .rst(rst), .i_rx(rx), .i_len(len), .i_parity_ty(pty),
        .i_parity_en(pen), .i_stop2(s2), .o_rx_data(data1), .o_rx_done(done1),
        .o_rx_er(er1), .o_parity_er(perr1), .o_frame_er(ferr1), .o_rx_busy(busy1),
        .o_state(state1)
    );

    // ---------------- scoreboard ----------------
    // entry: {done cycle[31:0], data[7:0], parity_er, frame_er}
    logic [41:0] exp_q0[$];
    logic [41:0] exp_q1[$];
    int checks   = 0;
    int failures = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    always @(negedge clk) begin
        logic [41:0] e;
        if (done0) begin
            if (exp_q0.size() == 0) begin
                check("unexpected_done0", 32'(done0), 32'd0);
            end else begin
                e = exp_q0.pop_front();
                check("done_cycle0", 32'(cyc), e[41:10]);
                check("data0", 32'(data0), 32'(e[9:2]));
                check("parity_er0", 32'(perr0), 32'(e[1]));
                check("frame_er0", 32'(ferr0), 32'(e[0]));
                check("rx_er0", 32'(er0), 32'(e[1] | e[0]));
            end
        end
    end

    always @(negedge clk) begin
        logic [41:0] e;
        if (done1) begin
            if (exp_q1.size() == 0) begin
                check("unexpected_done1", 32'(done1), 32'd0);
            end else begin
                e = exp_q1.pop_front();
                check("done_cycle1", 32'(cyc), e[41:10]);
                check("data1", 32'(data1), 32'(e[9:2]));
                check("parity_er1", 32'(perr1), 32'(e[1]));
                check("frame_er1", 32'(ferr1), 32'(e[0]));
                check("rx_er1", 32'(er1), 32'(e[1] | e[0]));
            end
        end
    end

    // ---------------- driver ----------------
    // Sends one full frame including the trailing high slot that matches the DONE cycle.
    task automatic send_frame(input logic [7:0] d, input logic [3:0] l, input logic p_en,
                              input logic p_ty, input logic st2, input logic par_inv,
                              input logic stop2_zero, input logic [7:0] exp_d,
                              input logic exp_ferr);
        int   lw;
        int   nb;
        int   c0;
        logic par;
        lw  = (l >= 4'd5 && l <= 4'd8) ? int'(l) : 8;
        par = 1'b0;
        for (int i = 0; i < lw; i++) par = par ^ d[i];
        if (!p_ty) par = ~par;
        if (par_inv) par = ~par;
        nb = 1 + lw + int'(p_en) + 1 + int'(st2);
        @(negedge clk);
        len = l; pen = p_en; pty = p_ty; s2 = st2;
        rx  = 1'b0;
        c0  = cyc + 1;
        exp_q0.push_back({32'(c0 + nb - 1), exp_d, par_inv, exp_ferr});
        exp_q1.push_back({32'(c0 + nb + 1), exp_d, par_inv, exp_ferr});
        for (int i = 0; i < lw; i++) begin
            @(negedge clk);
            rx = d[i];
        end
        if (p_en) begin
            @(negedge clk);
            rx = par;
        end
        @(negedge clk);
        rx = 1'b1;
        if (st2) begin
            @(negedge clk);
            rx = ~stop2_zero;
        end
        @(negedge clk);
        rx = 1'b1;
    endtask

    task automatic idle_cycles(input int n);
        repeat (n) begin
            @(negedge clk);
            rx = 1'b1;
        end
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic [7:0] abort_d;
        rst = 1'b1; rx = 1'b1; len = 4'd8; pty = 1'b0; pen = 1'b0; s2 = 1'b0;
        #1;
        check("reset_data0", 32'(data0), 32'd0);
        check("reset_done0", 32'(done0), 32'd0);
        check("reset_busy0", 32'(busy0), 32'd0);
        check("reset_err0", 32'({er0, perr0, ferr0}), 32'd0);
        check("reset_state0", 32'(state0), 32'(IDLE));
        check("reset_data1", 32'(data1), 32'd0);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        idle_cycles(4);

        // 8N1 basic frame
        send_frame(8'hA5, 4'd8, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'hA5, 1'b0);
        idle_cycles(2);
        // 5 bits, odd-sense parity, correct then inverted parity bit
        send_frame(8'hFF, 4'd5, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'h1F, 1'b0);
        idle_cycles(2);
        send_frame(8'hFF, 4'd5, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 8'h1F, 1'b0);
        idle_cycles(2);
        // 7 bits, two stops, second stop low; then a clean frame
        send_frame(8'h6B, 4'd7, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 8'h6B, 1'b1);
        idle_cycles(1);
        send_frame(8'h3C, 4'd8, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h3C, 1'b0);
        // back-to-back, no idle gap
        send_frame(8'h00, 4'd8, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
        send_frame(8'hFF, 4'd8, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'hFF, 1'b0);
        send_frame(8'h55, 4'd8, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h55, 1'b0);
        idle_cycles(3);
        // 6 bits: plain, and with even-sense parity (three ones -> parity bit 0)
        send_frame(8'h2A, 4'd6, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h2A, 1'b0);
        send_frame(8'h2A, 4'd6, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h2A, 1'b0);
        // 8 bits with parity and two clean stops; upper bits truncated at len 5
        send_frame(8'hC6, 4'd8, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 8'hC6, 1'b0);
        send_frame(8'hEA, 4'd5, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h0A, 1'b0);
        // illegal length: taken as 8 bits with frame error
        send_frame(8'h5A, 4'd4, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h5A, 1'b1);
        idle_cycles(4);

        // async reset during bit 3 of 8'hC3
        abort_d = 8'hC3;
        len = 4'd8; pen = 1'b0; s2 = 1'b0;
        @(negedge clk);
        rx = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            rx = abort_d[i];
        end
        #2;
        check("busy_before_abort0", 32'(busy0), 32'd1);
        check("data_before_abort0", 32'(data0), 32'h5A);
        rst = 1'b1;
        #1;
        check("abort_data0", 32'(data0), 32'd0);
        check("abort_busy0", 32'(busy0), 32'd0);
        check("abort_state0", 32'(state0), 32'(IDLE));
        check("abort_err0", 32'({er0, perr0, ferr0}), 32'd0);
        check("abort_busy1", 32'(busy1), 32'd0);
        check("abort_data1", 32'(data1), 32'd0);
        @(negedge clk);
        rx = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        idle_cycles(3);
        send_frame(8'h81, 4'd8, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h81, 1'b0);

        idle_cycles(12);
        check("pending_frames0", 32'(exp_q0.size()), 32'd0);
        check("pending_frames1", 32'(exp_q1.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
